// File: rtl/decode_issue_reg_if.sv
// Fetch-to-decode bundle: IF slot, hazard and control inputs, the issued ID slot and
// the fetch-side enables.
interface decode_issue_reg_if;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_PLUS_FOUR;
  logic [31:0] IF_INSTR;
  logic        FLUSH;
  logic        EXT_STALL;
  logic [4:0]  EX_RD;
  logic        EX_MEM_READ;
  logic        PC_WRITE;
  logic        LOAD_USE;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC_PLUS_FOUR;
  logic [31:0] ID_INSTR;
  logic        ID_VALID;

  modport master (
    output IF_PC, IF_PC_PLUS_FOUR, IF_INSTR, FLUSH, EXT_STALL, EX_RD, EX_MEM_READ,
    input  PC_WRITE, LOAD_USE, ID_PC, ID_PC_PLUS_FOUR, ID_INSTR, ID_VALID
  );

  modport slave (
    input  IF_PC, IF_PC_PLUS_FOUR, IF_INSTR, FLUSH, EXT_STALL, EX_RD, EX_MEM_READ,
    output PC_WRITE, LOAD_USE, ID_PC, ID_PC_PLUS_FOUR, ID_INSTR, ID_VALID
  );
endinterface

// File: rtl/decode_issue_reg.sv
// IF/ID boundary register: issues one instruction per cycle, parks a slot across stalls,
// inserts load-use bubbles and squashes wrong-path slots after a redirect.
module decode_issue_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RST_PC    = 32'h0000_0000
) (
  input logic               ID_CLK,
  input logic               ID_RESET_N,
  decode_issue_reg_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] park_pc_q, park_pc_d;
  logic [31:0] park_pc4_q, park_pc4_d;
  logic [31:0] park_instr_q, park_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] cur_pc, cur_pc4, cur_instr;
  logic [6:0]  opcode;
  logic        uses_rs1, uses_rs2, load_use;

  always_comb begin
    if (state_q == ST_HOLD) begin
      cur_pc    = park_pc_q;
      cur_pc4   = park_pc4_q;
      cur_instr = park_instr_q;
    end else begin
      cur_pc    = bus.IF_PC;
      cur_pc4   = bus.IF_PC_PLUS_FOUR;
      cur_instr = bus.IF_INSTR;
    end
  end

  assign opcode   = cur_instr[6:0];
  assign uses_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
  assign uses_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);

  assign load_use = (state_q != ST_SQUASH) && bus.EX_MEM_READ && (bus.EX_RD != 5'd0) &&
                    ((uses_rs1 && (bus.EX_RD == cur_instr[19:15])) ||
                     (uses_rs2 && (bus.EX_RD == cur_instr[24:20])));

  // A redirect must always load the PC, even while a stall or hazard is pending.
  assign bus.LOAD_USE = load_use;
  assign bus.PC_WRITE = !(bus.EXT_STALL || load_use) || bus.FLUSH;

  always_comb begin
    state_d      = state_q;
    park_pc_d    = park_pc_q;
    park_pc4_d   = park_pc4_q;
    park_instr_d = park_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;

    if (bus.FLUSH) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      state_d    = ST_SQUASH;
    end else if (state_q == ST_SQUASH) begin
      if (!bus.EXT_STALL) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
      state_d = ST_RUN;
    end else if (bus.EXT_STALL || load_use) begin
      if (state_q == ST_RUN) begin
        park_pc_d    = bus.IF_PC;
        park_pc4_d   = bus.IF_PC_PLUS_FOUR;
        park_instr_d = bus.IF_INSTR;
      end
      if (!bus.EXT_STALL) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
      state_d = ST_HOLD;
    end else begin
      id_pc_d    = cur_pc;
      id_pc4_d   = cur_pc4;
      id_instr_d = cur_instr;
      id_valid_d = 1'b1;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge ID_CLK) begin
    if (!ID_RESET_N) begin
      state_q      <= ST_SQUASH;
      park_pc_q    <= RST_PC;
      park_pc4_q   <= RST_PC + 32'd4;
      park_instr_q <= NOP_INSTR;
      id_pc_q      <= RST_PC;
      id_pc4_q     <= RST_PC + 32'd4;
      id_instr_q   <= NOP_INSTR;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      park_pc_q    <= park_pc_d;
      park_pc4_q   <= park_pc4_d;
      park_instr_q <= park_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign bus.ID_PC           = id_pc_q;
  assign bus.ID_PC_PLUS_FOUR = id_pc4_q;
  assign bus.ID_INSTR        = id_valid_q ? id_instr_q : NOP_INSTR;
  assign bus.ID_VALID        = id_valid_q;

endmodule

// File: tb/tb_decode_issue_reg.sv
// Directed bench for decode_issue_reg: the driver checks the combinational hazard outputs
// and queues the registered outputs expected after each edge; a monitor pops and compares.
module tb_decode_issue_reg;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] I_A   = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] I_B   = 32'h0020_0113;  // addi x2,x0,2
  localparam logic [31:0] I_C   = 32'h0030_0193;  // addi x3,x0,3
  localparam logic [31:0] ADD1  = 32'h0072_8333;  // add x6,x5,x7
  localparam logic [31:0] ADD2  = 32'h0053_8333;  // add x6,x7,x5
  localparam logic [31:0] LUI5  = 32'h0002_82B7;  // lui x5,0x28 (bits 19:15 = 5)

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    string       nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  bit   done;
  exp_t expq[$];

  decode_issue_reg_if bus();

  decode_issue_reg #(.NOP_INSTR(32'h0000_0013), .RST_PC(32'h0000_0000)) dut (
    .ID_CLK    (clk),
    .ID_RESET_N(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // One cycle of stimulus: drive inputs, check combinational outputs, queue expected ID slot.
  task automatic cyc(input logic rn, input logic [31:0] pc, input logic [31:0] instr,
                     input logic fl, input logic st, input logic [4:0] rd, input logic mr,
                     input logic e_lu, input logic e_pcw,
                     input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_in,
                     input string nm);
    exp_t e;
    @(negedge clk);
    rst_n                = rn;
    bus.IF_PC            = pc;
    bus.IF_PC_PLUS_FOUR  = pc + 32'd4;
    bus.IF_INSTR         = instr;
    bus.FLUSH            = fl;
    bus.EXT_STALL        = st;
    bus.EX_RD            = rd;
    bus.EX_MEM_READ      = mr;
    #1;
    chk({nm, ".LOAD_USE"}, {31'd0, bus.LOAD_USE}, {31'd0, e_lu});
    chk({nm, ".PC_WRITE"}, {31'd0, bus.PC_WRITE}, {31'd0, e_pcw});
    e.v = e_v; e.pc = e_pc; e.instr = e_in; e.nm = nm;
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk({e.nm, ".ID_VALID"}, {31'd0, bus.ID_VALID}, {31'd0, e.v});
        chk({e.nm, ".ID_PC"}, bus.ID_PC, e.pc);
        chk({e.nm, ".ID_PC_PLUS_FOUR"}, bus.ID_PC_PLUS_FOUR, e.pc + 32'd4);
        chk({e.nm, ".ID_INSTR"}, bus.ID_INSTR, e.instr);
      end
    end
  end

  initial begin : watchdog
    #20000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete, required completion");
      $fatal(1, "timeout");
    end
  end

  initial begin
    checks = 0; passes = 0; done = 1'b0;
    rst_n = 1'b0;
    bus.IF_PC = '0; bus.IF_PC_PLUS_FOUR = 32'd4; bus.IF_INSTR = NOP;
    bus.FLUSH = 1'b0; bus.EXT_STALL = 1'b0; bus.EX_RD = '0; bus.EX_MEM_READ = 1'b0;

    //  rn   pc        instr  fl st rd mr  lu pcw  v  id_pc     id_instr
    // reset and first stale slot
    cyc(0, 32'h00, I_A,  0, 0, 0, 0,  0, 1,  0, 32'h00, NOP,  "rst0");
    cyc(0, 32'h00, I_A,  0, 0, 0, 0,  0, 1,  0, 32'h00, NOP,  "rst1");
    cyc(1, 32'h00, I_C,  0, 0, 0, 0,  0, 1,  0, 32'h00, NOP,  "stale");
    cyc(1, 32'h00, I_A,  0, 0, 0, 0,  0, 1,  1, 32'h00, I_A,  "iss0");
    cyc(1, 32'h04, I_B,  0, 0, 0, 0,  0, 1,  1, 32'h04, I_B,  "iss4");
    cyc(1, 32'h08, I_C,  0, 0, 0, 0,  0, 1,  1, 32'h08, I_C,  "iss8");
    // load-use on rs1, then parked slot issues
    cyc(1, 32'h10, ADD1, 0, 0, 5, 1,  1, 0,  0, 32'h08, NOP,  "lu_rs1");
    cyc(1, 32'h14, I_A,  0, 0, 0, 0,  0, 1,  1, 32'h10, ADD1, "lu_issue");
    cyc(1, 32'h14, I_A,  0, 0, 0, 0,  0, 1,  1, 32'h14, I_A,  "lu_next");
    // no false hazard
    cyc(1, 32'h18, ADD1, 0, 0, 0, 1,  0, 1,  1, 32'h18, ADD1, "rd0");
    cyc(1, 32'h1C, LUI5, 0, 0, 5, 1,  0, 1,  1, 32'h1C, LUI5, "lui");
    // flush: two-cycle kill, then redirect target
    cyc(1, 32'h20, I_A,  1, 0, 0, 0,  0, 1,  0, 32'h1C, NOP,  "flush");
    cyc(1, 32'h24, I_B,  0, 0, 0, 0,  0, 1,  0, 32'h1C, NOP,  "squash");
    cyc(1, 32'h80, I_B,  0, 0, 0, 0,  0, 1,  1, 32'h80, I_B,  "target");
    // load-use on rs2
    cyc(1, 32'h84, ADD2, 0, 0, 5, 1,  1, 0,  0, 32'h80, NOP,  "lu_rs2");
    cyc(1, 32'h88, I_C,  0, 0, 0, 0,  0, 1,  1, 32'h84, ADD2, "rs2_issue");
    cyc(1, 32'h88, I_C,  0, 0, 0, 0,  0, 1,  1, 32'h88, I_C,  "rs2_next");
    // external stall, three cycles
    cyc(1, 32'h30, I_A,  0, 1, 0, 0,  0, 0,  1, 32'h88, I_C,  "stall0");
    cyc(1, 32'h30, I_A,  0, 1, 0, 0,  0, 0,  1, 32'h88, I_C,  "stall1");
    cyc(1, 32'h30, I_A,  0, 1, 0, 0,  0, 0,  1, 32'h88, I_C,  "stall2");
    cyc(1, 32'h34, I_B,  0, 0, 0, 0,  0, 1,  1, 32'h30, I_A,  "unstall");
    cyc(1, 32'h34, I_B,  0, 0, 0, 0,  0, 1,  1, 32'h34, I_B,  "after34");
    // flush with stall while holding: parked 0x30 must never issue
    cyc(1, 32'h30, I_C,  0, 1, 0, 0,  0, 0,  1, 32'h34, I_B,  "park30");
    cyc(1, 32'h30, I_C,  1, 1, 0, 0,  0, 1,  0, 32'h34, NOP,  "flush_hold");
    cyc(1, 32'h30, I_C,  0, 0, 0, 0,  0, 1,  0, 32'h34, NOP,  "squash2");
    cyc(1, 32'h90, I_A,  0, 0, 0, 0,  0, 1,  1, 32'h90, I_A,  "target2");
    // reset while holding discards the parked slot
    cyc(1, 32'h94, I_B,  0, 1, 0, 0,  0, 0,  1, 32'h90, I_A,  "park94");
    cyc(0, 32'h94, I_B,  0, 0, 0, 0,  0, 1,  0, 32'h00, NOP,  "rst_hold");
    cyc(1, 32'h94, I_B,  0, 0, 0, 0,  0, 1,  0, 32'h00, NOP,  "stale2");
    cyc(1, 32'h00, I_A,  0, 0, 0, 0,  0, 1,  1, 32'h00, I_A,  "restart");

    @(posedge clk);
    #3;
    chk("queue_drained", expq.size(), 32'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
